ct_hpcp_cnten_bank: RTL and testbench
=====================================

# ct_hpcp_cnten_bank

Parametrised bank of per-channel, per-privilege-level counter-enable registers for the HPCP (performance monitor) unit. It generalises the single 4-bit enable register to CNT_NUM channels and PLV_NUM privilege levels, and adds several behaviours:
- indexed read/write access;
- registered enable outputs with a global freeze;
- sticky per-channel overflow pending bits;
- an interrupt request/acknowledge state machine.

It sits between the HPCP CSR decode logic and the event counters.

## Interface
Parameters:
- CNT_NUM, 8, number of counter channels (1..32)
- IDX_W, 3, channel index width; 2**IDX_W >= CNT_NUM
- PRIV_W, 2, privilege mode width
- PLV_NUM, 4, enable bits per channel; must equal 2**PRIV_W

Ports:
- hpcp_clk  in  1  clock
- cpurst  in  1  reset; synchronous, active-high
- cp0_yy_priv_mode  in  PRIV_W  current privilege level
- hpcp_freeze  in  1  global count inhibit
- cnten_wen  in  1  write strobe
- cnten_widx  in  IDX_W  channel index for the write
- hpcp_wdata  in  PLV_NUM  write data; bit k enables counting at privilege level k
- cnten_ren  in  1  read strobe
- cnten_ridx  in  IDX_W  channel index for the read
- cnten_rdata  out  PLV_NUM  read data, registered
- cntinten  out  CNT_NUM  per-channel count enable, registered
- cnt_ovf  in  CNT_NUM  counter overflow pulses
- ovf_clr  in  CNT_NUM  pending clear pulses (write-1-to-clear)
- ovf_pending  out  CNT_NUM  sticky overflow pending bits
- hpcp_int_req  out  1  interrupt request
- hpcp_int_ack  in  1  interrupt acknowledge

## Operation
- Storage: plv[i][k] for i < CNT_NUM, k < PLV_NUM.
- Write: when cnten_wen is high and cnten_widx < CNT_NUM, plv[widx] takes hpcp_wdata. A write with an out-of-range index is ignored.
- Read: when cnten_ren is high, cnten_rdata takes plv[ridx] on the next edge.
  - An out-of-range ridx returns 0.
  - When ren is low, cnten_rdata holds its value.
  - A read and a write to the same index in the same cycle return the new (written) data.
- Enable: each edge, cntinten[i] <= plv[i][cp0_yy_priv_mode] & ~hpcp_freeze.
- Overflow: ovf_pending[i] sets on cnt_ovf[i] and clears on ovf_clr[i]. When set and clear arrive in the same cycle, set wins.
- Interrupt state machine:
  - IDLE: hpcp_int_req = 0. Moves to REQ when |ovf_pending = 1.
  - REQ: hpcp_int_req = 1. Moves to SERVICE when hpcp_int_ack = 1.
  - SERVICE: hpcp_int_req = 0. Moves to IDLE when ovf_pending == 0. New overflows arriving here keep the machine in SERVICE.
  - hpcp_int_ack is ignored outside REQ.
- Reset (cpurst) at any point, including mid-handshake: all plv = 0, cntinten = 0, cnten_rdata = 0, ovf_pending = 0, state = IDLE, hpcp_int_req = 0.

## Timing
- Write at edge E: plv updates at E, and cntinten reflects the new value at E+1 (2-cycle write-to-enable latency).
- Privilege or freeze change sampled at edge E appears on cntinten after E (1-cycle latency).
- Read strobe at edge E: cnten_rdata is valid after E.
- cnt_ovf sampled at edge E: ovf_pending is set after E, hpcp_int_req rises after E+1.
- hpcp_int_ack sampled at edge E while in REQ: hpcp_int_req falls after E.
- Pending clears to all-zero at edge E while in SERVICE: state is IDLE after E+1.
  - If a new overflow arrives at E+1, hpcp_int_req rises after E+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- HPCP_OVF_INT_EN defined: overflow pending bits and the interrupt state machine are built as described above.
- HPCP_OVF_INT_EN not defined:
  - ovf_pending and hpcp_int_req are tied to 0;
  - cnt_ovf, ovf_clr and hpcp_int_ack are unused;
  - no state-machine or pending flops are instantiated.
- Enable-register and read/write behaviour is identical in both builds.

## Test plan
- Reset, then write widx=2, wdata=4'b0110; priv held at 1. Expect cntinten == 8'h04 two edges after the write; read of idx 2 returns 4'b0110.
- Same setup, switch priv 1->3. Expect cntinten[2] = 0 one edge later; assert hpcp_freeze with priv at 1 and expect cntinten == 0 one edge later.
- Write widx=2 (CNT_NUM=2, 2-bit index) and read ridx=3. Expect no register change and cnten_rdata == 0; read and write idx 1 in the same cycle returns the written data.
- cnt_ovf[5] pulse. Expect ovf_pending = 8'h20 after 1 edge and int_req = 1 after 2; ack drops int_req; ovf_clr[5] returns the machine to IDLE.
- In SERVICE, assert ovf_clr[5] together with cnt_ovf[5]. Expect pending stays set and state stays SERVICE; assert cpurst mid-REQ and expect every output = 0 next edge.
- Build without HPCP_OVF_INT_EN, drive cnt_ovf = 8'hFF. Expect ovf_pending == 0 and hpcp_int_req == 0 throughout.

Source files
------------

// File: rtl/ct_hpcp_cnten_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : ct_hpcp_cnten_bank_if
//  Brief    : Bus between the HPCP CSR decode logic (master) and the
//             counter-enable bank (slave): indexed enable-register access,
//             per-channel count enables, overflow pending and interrupt
//             handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface ct_hpcp_cnten_bank_if #(
    parameter int CNT_NUM = 8,
    parameter int IDX_W   = 3,
    parameter int PRIV_W  = 2,
    parameter int PLV_NUM = 4
);
    logic [PRIV_W-1:0]  cp0_yy_priv_mode;
    logic               hpcp_freeze;
    logic               cnten_wen;
    logic [IDX_W-1:0]   cnten_widx;
    logic [PLV_NUM-1:0] hpcp_wdata;
    logic               cnten_ren;
    logic [IDX_W-1:0]   cnten_ridx;
    logic [PLV_NUM-1:0] cnten_rdata;
    logic [CNT_NUM-1:0] cntinten;
    logic [CNT_NUM-1:0] cnt_ovf;
    logic [CNT_NUM-1:0] ovf_clr;
    logic [CNT_NUM-1:0] ovf_pending;
    logic               hpcp_int_req;
    logic               hpcp_int_ack;

    modport master (
        output cp0_yy_priv_mode, hpcp_freeze,
        output cnten_wen, cnten_widx, hpcp_wdata,
        output cnten_ren, cnten_ridx,
        output cnt_ovf, ovf_clr, hpcp_int_ack,
        input  cnten_rdata, cntinten, ovf_pending, hpcp_int_req
    );

    modport slave (
        input  cp0_yy_priv_mode, hpcp_freeze,
        input  cnten_wen, cnten_widx, hpcp_wdata,
        input  cnten_ren, cnten_ridx,
        input  cnt_ovf, ovf_clr, hpcp_int_ack,
        output cnten_rdata, cntinten, ovf_pending, hpcp_int_req
    );
endinterface
`default_nettype wire

// File: rtl/ct_hpcp_cnten_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ct_hpcp_cnten_bank
//  Brief    : Bank of CNT_NUM x PLV_NUM counter-enable bits for the HPCP
//             unit. Indexed read/write, registered per-channel enables with
//             global freeze, and (when HPCP_OVF_INT_EN is defined) sticky
//             overflow pending bits plus an interrupt req/ack machine.
//  Macro    : HPCP_OVF_INT_EN - builds the overflow / interrupt logic;
//             otherwise ovf_pending and hpcp_int_req are tied low.
//  Revision : 1.0  initial release
// ============================================================================
module ct_hpcp_cnten_bank #(
    parameter int CNT_NUM = 8,
    parameter int IDX_W   = 3,
    parameter int PRIV_W  = 2,
    parameter int PLV_NUM = 4
) (
    input  wire logic             hpcp_clk,
    input  wire logic             cpurst,
    ct_hpcp_cnten_bank_if.slave   bus
);

    // ------------------------------------------------------------------
    // Enable storage
    // ------------------------------------------------------------------
    logic [PLV_NUM-1:0] plv_q [CNT_NUM];
    logic [PLV_NUM-1:0] plv_d [CNT_NUM];
    logic [PLV_NUM-1:0] cnten_rdata_q;
    logic [PLV_NUM-1:0] cnten_rdata_d;
    logic [CNT_NUM-1:0] cntinten_q;
    logic [CNT_NUM-1:0] cntinten_d;

    // Write decode: only indices below CNT_NUM match, so out-of-range
    // writes fall through without touching any channel.
    always_comb begin
        for (int i = 0; i < CNT_NUM; i++) begin
            plv_d[i] = plv_q[i];
            if (bus.cnten_wen && (bus.cnten_widx == IDX_W'(i))) begin
                plv_d[i] = bus.hpcp_wdata;
            end
        end
    end

    // Read mux taken from next-state so a same-cycle write is returned;
    // an index with no channel behind it reads as zero.
    always_comb begin
        cnten_rdata_d = cnten_rdata_q;
        if (bus.cnten_ren) begin
            cnten_rdata_d = '0;
            for (int i = 0; i < CNT_NUM; i++) begin
                if (bus.cnten_ridx == IDX_W'(i)) begin
                    cnten_rdata_d = plv_d[i];
                end
            end
        end
    end

    // Per-channel enable selects the bit for the current privilege level.
    always_comb begin
        for (int i = 0; i < CNT_NUM; i++) begin
            cntinten_d[i] = plv_q[i][bus.cp0_yy_priv_mode] & ~bus.hpcp_freeze;
        end
    end

    // Enable registers, read-data register and count-enable outputs.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            for (int i = 0; i < CNT_NUM; i++) begin
                plv_q[i] <= '0;
            end
            cnten_rdata_q <= '0;
            cntinten_q    <= '0;
        end else begin
            for (int i = 0; i < CNT_NUM; i++) begin
                plv_q[i] <= plv_d[i];
            end
            cnten_rdata_q <= cnten_rdata_d;
            cntinten_q    <= cntinten_d;
        end
    end

    assign bus.cnten_rdata = cnten_rdata_q;
    assign bus.cntinten    = cntinten_q;

`ifdef HPCP_OVF_INT_EN
    // ------------------------------------------------------------------
    // Overflow pending bits and interrupt handshake
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_req     = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CNT_NUM-1:0] ovf_pending_q;
    logic [CNT_NUM-1:0] ovf_pending_d;
    logic               int_req_q;
    logic               int_req_d;

    // Pending bits are sticky; a set in the same cycle as a clear wins.
    // The machine only leaves SERVICE once every pending bit is gone.
    always_comb begin
        ovf_pending_d = (ovf_pending_q & ~bus.ovf_clr) | bus.cnt_ovf;
        state_d       = state_q;
        case (state_q)
            c_st_idle: begin
                if (|ovf_pending_q) begin
                    state_d = c_st_req;
                end
            end
            c_st_req: begin
                if (bus.hpcp_int_ack) begin
                    state_d = c_st_service;
                end
            end
            c_st_service: begin
                if (ovf_pending_q == '0) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
        int_req_d = (state_d == c_st_req);
    end

    // Pending, state and request flops.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            ovf_pending_q <= '0;
            state_q       <= c_st_idle;
            int_req_q     <= 1'b0;
        end else begin
            ovf_pending_q <= ovf_pending_d;
            state_q       <= state_d;
            int_req_q     <= int_req_d;
        end
    end

    assign bus.ovf_pending  = ovf_pending_q;
    assign bus.hpcp_int_req = int_req_q;
`else
    // Overflow inputs have no sink in this build.
    logic w_unused;
    assign w_unused = ^{bus.cnt_ovf, bus.ovf_clr, bus.hpcp_int_ack};

    assign bus.ovf_pending  = '0;
    assign bus.hpcp_int_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_hpcp_cnten_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ct_hpcp_cnten_bank
//  Brief    : Directed bench for ct_hpcp_cnten_bank: vector table for the
//             enable/read path, hand sequences for the narrow-index build,
//             overflow/interrupt handshake and mid-handshake reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ct_hpcp_cnten_bank;

`ifdef HPCP_OVF_INT_EN
    localparam bit c_ovf = 1'b1;
`else
    localparam bit c_ovf = 1'b0;
`endif

    logic hpcp_clk;
    logic cpurst;

    ct_hpcp_cnten_bank_if #(.CNT_NUM(8), .IDX_W(3), .PRIV_W(2), .PLV_NUM(4)) bus ();
    ct_hpcp_cnten_bank_if #(.CNT_NUM(2), .IDX_W(2), .PRIV_W(2), .PLV_NUM(4)) sbus ();

    ct_hpcp_cnten_bank #(.CNT_NUM(8), .IDX_W(3), .PRIV_W(2), .PLV_NUM(4)) u_dut (
        .hpcp_clk (hpcp_clk),
        .cpurst   (cpurst),
        .bus      (bus.slave)
    );

    ct_hpcp_cnten_bank #(.CNT_NUM(2), .IDX_W(2), .PRIV_W(2), .PLV_NUM(4)) u_dut_small (
        .hpcp_clk (hpcp_clk),
        .cpurst   (cpurst),
        .bus      (sbus.slave)
    );

    initial hpcp_clk = 1'b0;
    always #5 hpcp_clk = ~hpcp_clk;

    typedef struct {
        logic       wen;
        logic [2:0] widx;
        logic [3:0] wdata;
        logic       ren;
        logic [2:0] ridx;
        logic [1:0] priv;
        logic       frz;
        logic [7:0] exp_en;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t tbl [12];
    int   n_vec;
    int   n_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hpcp_clk);
        #1;
    endtask

    task automatic idle_main();
        bus.cnten_wen    = 1'b0;
        bus.cnten_widx   = '0;
        bus.hpcp_wdata   = '0;
        bus.cnten_ren    = 1'b0;
        bus.cnten_ridx   = '0;
        bus.cnt_ovf      = '0;
        bus.ovf_clr      = '0;
        bus.hpcp_int_ack = 1'b0;
    endtask

    task automatic small_cycle(input logic wen, input logic [1:0] widx, input logic [3:0] wd,
                               input logic ren, input logic [1:0] ridx,
                               input logic [3:0] exp_rd, input logic [1:0] exp_en, input string nm);
        sbus.cnten_wen  = wen;
        sbus.cnten_widx = widx;
        sbus.hpcp_wdata = wd;
        sbus.cnten_ren  = ren;
        sbus.cnten_ridx = ridx;
        tick();
        check({nm, "_rdata"}, 32'(sbus.cnten_rdata), 32'(exp_rd));
        check({nm, "_en"},    32'(sbus.cntinten),    32'(exp_en));
    endtask

    task automatic ovf_cycle(input logic [7:0] ovf, input logic [7:0] clr, input logic ack,
                             input logic [7:0] exp_pend, input logic exp_req, input string nm);
        bus.cnt_ovf      = ovf;
        bus.ovf_clr      = clr;
        bus.hpcp_int_ack = ack;
        tick();
        check({nm, "_pend"}, 32'(bus.ovf_pending),  32'(exp_pend & {8{c_ovf}}));
        check({nm, "_req"},  32'(bus.hpcp_int_req), 32'(exp_req & c_ovf));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //             wen widx wdata    ren ridx priv frz  en     rd
        tbl[0]  = '{1'b1, 3'd2, 4'b0110, 1'b0, 3'd0, 2'd1, 1'b0, 8'h00, 4'b0000};
        tbl[1]  = '{1'b0, 3'd0, 4'b0000, 1'b1, 3'd2, 2'd1, 1'b0, 8'h04, 4'b0110};
        tbl[2]  = '{1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 2'd3, 1'b0, 8'h00, 4'b0110};
        tbl[3]  = '{1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 2'd2, 1'b0, 8'h04, 4'b0110};
        tbl[4]  = '{1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 2'd1, 1'b1, 8'h00, 4'b0110};
        tbl[5]  = '{1'b1, 3'd7, 4'b1111, 1'b1, 3'd7, 2'd1, 1'b0, 8'h04, 4'b1111};
        tbl[6]  = '{1'b0, 3'd0, 4'b0000, 1'b1, 3'd3, 2'd0, 1'b0, 8'h80, 4'b0000};
        tbl[7]  = '{1'b0, 3'd0, 4'b0000, 1'b1, 3'd7, 2'd1, 1'b0, 8'h84, 4'b1111};
        tbl[8]  = '{1'b1, 3'd0, 4'b1000, 1'b0, 3'd0, 2'd3, 1'b0, 8'h80, 4'b1111};
        tbl[9]  = '{1'b0, 3'd0, 4'b0000, 1'b1, 3'd0, 2'd3, 1'b0, 8'h81, 4'b1000};
        tbl[10] = '{1'b1, 3'd2, 4'b0000, 1'b1, 3'd2, 2'd1, 1'b0, 8'h84, 4'b0000};
        tbl[11] = '{1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 2'd1, 1'b0, 8'h80, 4'b0000};

        cpurst = 1'b1;
        idle_main();
        bus.cp0_yy_priv_mode = 2'd1;
        bus.hpcp_freeze      = 1'b0;
        sbus.cp0_yy_priv_mode = 2'd1;
        sbus.hpcp_freeze      = 1'b0;
        sbus.cnten_wen  = 1'b0;
        sbus.cnten_widx = '0;
        sbus.hpcp_wdata = '0;
        sbus.cnten_ren  = 1'b0;
        sbus.cnten_ridx = '0;
        sbus.cnt_ovf    = '0;
        sbus.ovf_clr    = '0;
        sbus.hpcp_int_ack = 1'b0;
        tick();
        tick();
        check("rst_en",    32'(bus.cntinten),     32'h0);
        check("rst_rdata", 32'(bus.cnten_rdata),  32'h0);
        check("rst_pend",  32'(bus.ovf_pending),  32'h0);
        check("rst_req",   32'(bus.hpcp_int_req), 32'h0);
        check("rst_small_en", 32'(sbus.cntinten), 32'h0);
        cpurst = 1'b0;

        // Enable / read path vectors
        for (int v = 0; v < 12; v++) begin
            bus.cnten_wen        = tbl[v].wen;
            bus.cnten_widx       = tbl[v].widx;
            bus.hpcp_wdata       = tbl[v].wdata;
            bus.cnten_ren        = tbl[v].ren;
            bus.cnten_ridx       = tbl[v].ridx;
            bus.cp0_yy_priv_mode = tbl[v].priv;
            bus.hpcp_freeze      = tbl[v].frz;
            tick();
            check($sformatf("vec%0d_en", v), 32'(bus.cntinten),    32'(tbl[v].exp_en));
            check($sformatf("vec%0d_rd", v), 32'(bus.cnten_rdata), 32'(tbl[v].exp_rd));
        end
        idle_main();
        bus.cp0_yy_priv_mode = 2'd1;
        bus.hpcp_freeze      = 1'b0;

        // Narrow-index instance: bypass read, out-of-range write/read
        small_cycle(1'b1, 2'd1, 4'b1010, 1'b1, 2'd1, 4'b1010, 2'b00, "s_bypass");
        small_cycle(1'b1, 2'd2, 4'b1111, 1'b1, 2'd3, 4'b0000, 2'b10, "s_oor_r3");
        small_cycle(1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 4'b0000, 2'b10, "s_oor_r2");
        small_cycle(1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 4'b1010, 2'b10, "s_r1");
        small_cycle(1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0000, 2'b10, "s_r0");

        // Overflow and interrupt handshake
        ovf_cycle(8'h20, 8'h00, 1'b0, 8'h20, 1'b0, "o_set");
        ovf_cycle(8'h00, 8'h00, 1'b0, 8'h20, 1'b1, "o_req");
        ovf_cycle(8'h00, 8'h00, 1'b0, 8'h20, 1'b1, "o_hold");
        ovf_cycle(8'h00, 8'h00, 1'b1, 8'h20, 1'b0, "o_ack");
        ovf_cycle(8'h20, 8'h20, 1'b0, 8'h20, 1'b0, "o_setwin");
        ovf_cycle(8'h00, 8'h00, 1'b1, 8'h20, 1'b0, "o_svc_ack");
        ovf_cycle(8'h00, 8'h20, 1'b0, 8'h00, 1'b0, "o_clr");
        ovf_cycle(8'h20, 8'h00, 1'b0, 8'h20, 1'b0, "o_reset_idle");
        ovf_cycle(8'h00, 8'h00, 1'b0, 8'h20, 1'b1, "o_rereq");
        check("o_en_during", 32'(bus.cntinten), 32'h80);

        // Reset while the request is outstanding
        cpurst = 1'b1;
        tick();
        check("mr_en",    32'(bus.cntinten),     32'h0);
        check("mr_rdata", 32'(bus.cnten_rdata),  32'h0);
        check("mr_pend",  32'(bus.ovf_pending),  32'h0);
        check("mr_req",   32'(bus.hpcp_int_req), 32'h0);
        check("mr_small_rdata", 32'(sbus.cnten_rdata), 32'h0);
        cpurst = 1'b0;
        ovf_cycle(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "mr_idle");
        bus.cnten_ren  = 1'b1;
        bus.cnten_ridx = 3'd7;
        tick();
        check("mr_plv_cleared", 32'(bus.cnten_rdata), 32'h0);
        bus.cnten_ren  = 1'b0;
        ovf_cycle(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "o_all");
        ovf_cycle(8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, "o_all_req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
